prog_reader: RTL and testbench

- Parametrised successor to the team's fixed-program reader.
- 3-phase (FETCH/READ/EXEC) byte-RAM instruction processor with configurable data width, register count and RAM depth.
- Program and data are loaded through an external write port instead of a hard-coded init sequence.
- Adds sub, jump, jump-if-zero, halt and a retired-instruction counter.
- Sits in the test datapath as the programmable sequencer; r0/r1/debug are observed by the bench.

---
 rtl/prog_reader_if.sv | 17 +
 rtl/prog_reader.sv | 169 ++++++++++++++++
 tb/tb_prog_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_reader_if.sv
// Program-load port of prog_reader.
//   load_en   : RAM write strobe (honoured only while the reader is loading)
//   load_addr : RAM byte address to write
//   load_data : byte to write
//   start     : leave loading and begin execution at address 0
// master drives the port (loader / bench); slave is the reader.
interface prog_reader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [7:0]            load_data;
  logic                  start;

  modport master (output load_en, output load_addr, output load_data, output start);
  modport slave  (input  load_en, input  load_addr, input  load_data, input  start);
endinterface

// File: rtl/prog_reader.sv
// prog_reader: three-phase (fetch/read/exec) byte-RAM instruction processor.
// Instructions are 4 bytes: opcode, register byte, operand low, operand high.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   lp        : program-load port (load_en/load_addr/load_data/start)
//   dbg_addr  : RAM address mirrored on debug
//   ipointer  : address of the current instruction
//   opCode    : latched opcode of the current instruction
//   r0, r1    : registered copies of registers 0 and 1
//   debug     : registered ram[dbg_addr]
//   halted    : high once the halt instruction has executed
//   retired   : count of completed instructions (wraps at 2**16)
module prog_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAMSIZE    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  prog_reader_if.slave          lp,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [ADDR_WIDTH-1:0] ipointer,
  output logic [7:0]            opCode,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic [7:0]            debug,
  output logic                  halted,
  output logic [15:0]           retired
);

  localparam int RI = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_READ,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_MOV = 8'd1;
  localparam logic [7:0] OP_LD  = 8'd2;
  localparam logic [7:0] OP_ST  = 8'd3;
  localparam logic [7:0] OP_ADD = 8'd4;
  localparam logic [7:0] OP_SUB = 8'd5;
  localparam logic [7:0] OP_JMP = 8'd6;
  localparam logic [7:0] OP_JZ  = 8'd7;
  localparam logic [7:0] OP_HLT = 8'd8;

  state_t state_q, state_d;

  logic [7:0]            ram [RAMSIZE];
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [RI-1:0]         ra_q;
  logic [15:0]           operand_q;
  logic [7:0]            ramvalue_q;
  logic [DATA_WIDTH-1:0] rega_q;
  logic [DATA_WIDTH-1:0] regb_q;

  logic [ADDR_WIDTH-1:0] ip1, ip2, ip3, ip4, addr;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [7:0]            ram_wdata;

  // Instruction bytes wrap modulo RAMSIZE through ADDR_WIDTH-bit arithmetic.
  assign ip1  = ipointer + ADDR_WIDTH'(1);
  assign ip2  = ipointer + ADDR_WIDTH'(2);
  assign ip3  = ipointer + ADDR_WIDTH'(3);
  assign ip4  = ipointer + ADDR_WIDTH'(4);
  assign addr = operand_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (lp.start) state_d = S_FETCH;
      S_FETCH: state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = (opCode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_LOAD;
    endcase
  end

  // Single RAM write port shared by the loader and the store instruction.
  // Gated by reset so a store pending at reset assertion is discarded.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = lp.load_addr;
    ram_wdata = lp.load_data;
    if (state_q == S_LOAD && lp.load_en) begin
      ram_we = 1'b1;
    end else if (state_q == S_EXEC && opCode == OP_ST) begin
      ram_we    = 1'b1;
      ram_waddr = addr;
      ram_wdata = rega_q[7:0];
    end
    ram_we = ram_we & reset;
  end

  // RAM is deliberately not reset: program and stored data survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ipointer   <= '0;
      opCode     <= '0;
      r0         <= '0;
      r1         <= '0;
      debug      <= '0;
      halted     <= 1'b0;
      retired    <= '0;
      ra_q       <= '0;
      operand_q  <= '0;
      ramvalue_q <= '0;
      rega_q     <= '0;
      regb_q     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      r0    <= regs[0];
      r1    <= regs[1];
      debug <= ram[dbg_addr];
      case (state_q)
        S_LOAD: begin
          if (lp.start) ipointer <= '0;
        end
        S_FETCH: begin
          opCode    <= ram[ipointer];
          ra_q      <= ram[ip1][RI-1:0];
          operand_q <= {ram[ip3], ram[ip2]};
        end
        S_READ: begin
          ramvalue_q <= ram[addr];
          rega_q     <= regs[ra_q];
          regb_q     <= regs[operand_q[RI-1:0]];
        end
        S_EXEC: begin
          ipointer <= ip4;
          retired  <= retired + 16'd1;
          case (opCode)
            OP_MOV: regs[ra_q] <= DATA_WIDTH'(operand_q);
            OP_LD:  regs[ra_q] <= DATA_WIDTH'(ramvalue_q);
            OP_ADD: regs[ra_q] <= rega_q + regb_q;
            OP_SUB: regs[ra_q] <= rega_q - regb_q;
            OP_JMP: ipointer   <= addr;
            OP_JZ:  if (rega_q == '0) ipointer <= addr;
            OP_HLT: begin
              ipointer <= ipointer;
              halted   <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_reader.sv
module tb_prog_reader;

  logic        clk;
  logic        reset;
  logic [7:0]  dbg_addr;
  logic [7:0]  ipointer;
  logic [7:0]  opCode;
  logic [15:0] r0, r1;
  logic [7:0]  debug;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  prog_reader_if #(.ADDR_WIDTH(8)) lp ();

  prog_reader #(
    .DATA_WIDTH(16),
    .NUM_REGS  (16),
    .ADDR_WIDTH(8),
    .RAMSIZE   (256)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .lp      (lp),
    .dbg_addr(dbg_addr),
    .ipointer(ipointer),
    .opCode  (opCode),
    .r0      (r0),
    .r1      (r1),
    .debug   (debug),
    .halted  (halted),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    lp.load_en   = 1'b1;
    lp.load_addr = a;
    lp.load_data = d;
    tick();
    lp.load_en   = 1'b0;
  endtask

  task automatic instr(input logic [7:0] a, input logic [7:0] op, input logic [7:0] rb,
                       input logic [7:0] lo, input logic [7:0] hi);
    wr(a, op);
    wr(a + 8'd1, rb);
    wr(a + 8'd2, lo);
    wr(a + 8'd3, hi);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
  endtask

  task automatic go();
    lp.start = 1'b1;
    tick();
    lp.start = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    lp.load_en   = 1'b0;
    lp.load_addr = '0;
    lp.load_data = '0;
    lp.start     = 1'b0;
    dbg_addr     = 8'd18;
    tick(2);
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_ipointer", ipointer, 0);
    check("rst_opcode", opCode, 0);
    check("rst_r0", r0, 0);
    check("rst_r1", r1, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);

    // Load/add/store program; last data write coincides with start
    instr(8'd0,  8'd2, 8'd0, 8'd16, 8'd0);
    instr(8'd4,  8'd2, 8'd1, 8'd17, 8'd0);
    instr(8'd8,  8'd4, 8'd0, 8'd1,  8'd0);
    instr(8'd12, 8'd3, 8'd0, 8'd18, 8'd0);
    instr(8'd16, 8'd8, 8'd0, 8'd0,  8'd0);
    wr(8'd16 + 8'd0, 8'd8);
    wr(8'd18, 8'd0);
    lp.load_en   = 1'b1;
    lp.load_addr = 8'd17;
    lp.load_data = 8'd7;
    lp.start     = 1'b1;
    tick();
    lp.load_en   = 1'b0;
    lp.start     = 1'b0;
    // ram[16] holds the halt opcode and doubles as the first load's data (8)
    // so r0 = 8 + 7 = 15 and the stored low byte is 15.
    check("p1_ip_fetch", ipointer, 0);
    tick(14);
    check("p1_not_halted_14", halted, 0);
    tick();
    check("p1_halted", halted, 1);
    check("p1_ipointer", ipointer, 16);
    check("p1_retired", retired, 5);
    check("p1_r0", r0, 15);
    check("p1_r1", r1, 7);
    check("p1_debug", debug, 15);
    check("p1_opcode", opCode, 8);

    // HALT ignores start and load_en
    wr(8'd18, 8'h99);
    go();
    tick(2);
    check("halt_debug_kept", debug, 15);
    check("halt_ip_kept", ipointer, 16);
    check("halt_retired_kept", retired, 5);
    check("halt_still", halted, 1);

    // mov r2,3; sub r3,r2; add r0,r3; halt  -> r0 = 0 - 3
    do_reset();
    check("p2_rst_r0", r0, 0);
    instr(8'd0,  8'd1, 8'd2, 8'd3, 8'd0);
    instr(8'd4,  8'd5, 8'd3, 8'd2, 8'd0);
    instr(8'd8,  8'd4, 8'd0, 8'd3, 8'd0);
    instr(8'd12, 8'd8, 8'd0, 8'd0, 8'd0);
    wr(8'd60, 8'h33);
    dbg_addr = 8'd60;
    go();
    // load_en while running must not write
    lp.load_en   = 1'b1;
    lp.load_addr = 8'd60;
    lp.load_data = 8'h44;
    tick();
    lp.load_en   = 1'b0;
    tick(11);
    check("p2_halted", halted, 1);
    check("p2_r0", r0, 16'hFFFD);
    check("p2_retired", retired, 4);
    check("p2_ipointer", ipointer, 12);
    check("p2_debug_unwritten", debug, 8'h33);

    // Countdown loop
    do_reset();
    instr(8'd0,  8'd1, 8'd0, 8'd3,  8'd0);
    instr(8'd4,  8'd1, 8'd1, 8'd1,  8'd0);
    instr(8'd8,  8'd5, 8'd0, 8'd1,  8'd0);
    instr(8'd12, 8'd7, 8'd0, 8'd20, 8'd0);
    instr(8'd16, 8'd6, 8'd0, 8'd8,  8'd0);
    instr(8'd20, 8'd8, 8'd0, 8'd0,  8'd0);
    go();
    // mov,mov, (sub,jz,jmp)x2, sub,jz, halt = 11 instructions, 33 cycles
    tick(32);
    check("p3_not_halted_32", halted, 0);
    tick();
    check("p3_halted", halted, 1);
    check("p3_ipointer", ipointer, 20);
    check("p3_retired", retired, 11);
    check("p3_r0", r0, 0);
    check("p3_r1", r1, 1);

    // Address wrap: jz r0 -> 252; ld r0,[0x01F0] at 252; wraps to 0; jz not taken; halt at 4
    do_reset();
    instr(8'd0,   8'd7, 8'd0, 8'd252,  8'd0);
    instr(8'd4,   8'd8, 8'd0, 8'd0,    8'd0);
    instr(8'd252, 8'd2, 8'd0, 8'hF0,   8'h01);
    wr(8'hF0, 8'h2A);
    go();
    tick(3);
    check("p4_ip_252", ipointer, 252);
    tick(3);
    check("p4_ip_wrap", ipointer, 0);
    tick(3);
    check("p4_ip_4", ipointer, 4);
    tick(3);
    check("p4_halted", halted, 1);
    check("p4_r0", r0, 8'h2A);
    check("p4_retired", retired, 4);

    // Reset during EXEC of a store
    do_reset();
    instr(8'd0, 8'd1, 8'd0, 8'd9,  8'd0);
    instr(8'd4, 8'd3, 8'd0, 8'd40, 8'd0);
    instr(8'd8, 8'd8, 8'd0, 8'd0,  8'd0);
    wr(8'd40, 8'h11);
    dbg_addr = 8'd40;
    go();
    tick(5);
    check("p5_in_exec_opcode", opCode, 3);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick(2);
    check("p5_debug_no_store", debug, 8'h11);
    check("p5_r0", r0, 0);
    check("p5_r1", r1, 0);
    check("p5_ipointer", ipointer, 0);
    check("p5_retired", retired, 0);
    check("p5_halted", halted, 0);
    tick(4);
    check("p5_load_idle_ip", ipointer, 0);
    go();
    tick(9);
    check("p5_rerun_halted", halted, 1);
    check("p5_rerun_r0", r0, 9);
    check("p5_rerun_debug", debug, 9);
    check("p5_rerun_retired", retired, 3);
    check("p5_rerun_ip", ipointer, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
